// File: rtl/oam_dma_arbiter_if.sv
// Bus bundle for the OAM DMA arbiter: CPU side, mem_map side, HRAM side,
// the M-cycle strobe and the DMA-active flag.
interface oam_dma_arbiter_if;
  logic        mclk_in;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_write;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_write;
  logic [7:0]  mem_rdata;
  logic [6:0]  hram_addr;
  logic [7:0]  hram_wdata;
  logic        hram_write;
  logic [7:0]  hram_rdata;
  logic        dma_active;

  // Arbiter side
  modport slave (
    input  mclk_in, cpu_addr, cpu_wdata, cpu_write, mem_rdata, hram_rdata,
    output cpu_rdata, mem_addr, mem_wdata, mem_write,
           hram_addr, hram_wdata, hram_write, dma_active
  );

  // CPU / memory environment side
  modport master (
    output mclk_in, cpu_addr, cpu_wdata, cpu_write, mem_rdata, hram_rdata,
    input  cpu_rdata, mem_addr, mem_wdata, mem_write,
           hram_addr, hram_wdata, hram_write, dma_active
  );
endinterface

// File: rtl/oam_dma_arbiter.sv
// OAM DMA arbiter: copies DMA_LEN bytes from {src,00} into OAM, one byte per
// READ/WRITE M-cycle pair, while fencing the CPU off the main memory port.
// HRAM stays reachable by the CPU at all times.
module oam_dma_arbiter #(
  parameter int unsigned DMA_LEN      = 160,
  parameter logic [15:0] OAM_BASE     = 16'hFE00,
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46
) (
  input logic               clk_in,
  input logic               rst_in,
  oam_dma_arbiter_if.slave  bus
);

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  typedef enum logic [1:0] {IDLE, START, READ, WRITE} state_t;

  state_t     state_q, state_d;
  logic [7:0] src_q, src_d;
  logic [7:0] index_q, index_d;
  logic [7:0] buffer_q, buffer_d;
  logic       dma_active_q, dma_active_d;

  logic       hram_hit;
  logic       reg_hit;
  logic       reg_wr;
  logic       dma_busy;
  logic [7:0] eff_src;

  // Address decode and echo-RAM source mirroring
  always_comb begin
    hram_hit = (bus.cpu_addr >= 16'hFF80) && (bus.cpu_addr != 16'hFFFF);
    reg_hit  = (bus.cpu_addr == DMA_REG_ADDR);
    reg_wr   = reg_hit && bus.cpu_write;
    dma_busy = (state_q == READ) || (state_q == WRITE);
    eff_src  = (src_q >= 8'hE0) ? (src_q - 8'h20) : src_q;
  end

  // Next-state logic; everything advances only on M-cycle strobes
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    index_d  = index_q;
    buffer_d = buffer_q;
    if (bus.mclk_in) begin
      if (reg_wr) begin
        src_d   = bus.cpu_wdata;
        index_d = '0;
        state_d = START;
      end else begin
        case (state_q)
          START: begin
            index_d = '0;
            state_d = READ;
          end
          READ: begin
            buffer_d = bus.mem_rdata;
            state_d  = WRITE;
          end
          WRITE: begin
            if (index_q == LAST_IDX) begin
              state_d = IDLE;
            end else begin
              index_d = index_q + 8'd1;
              state_d = READ;
            end
          end
          default: state_d = state_q;
        endcase
      end
    end
    dma_active_d = (state_d == READ) || (state_d == WRITE);
  end

  // State registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      src_q        <= '0;
      index_q      <= '0;
      buffer_q     <= '0;
      dma_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      index_q      <= index_d;
      buffer_q     <= buffer_d;
      dma_active_q <= dma_active_d;
    end
  end

  // Bus steering: HRAM and the DMA register win over DMA/pass-through.
  // A restart landing on a WRITE cycle suppresses that byte's strobe.
  always_comb begin
    bus.hram_addr  = bus.cpu_addr[6:0];
    bus.hram_wdata = bus.cpu_wdata;
    bus.hram_write = !rst_in && hram_hit && bus.cpu_write;

    bus.mem_addr   = bus.cpu_addr;
    bus.mem_wdata  = bus.cpu_wdata;
    bus.mem_write  = 1'b0;
    case (state_q)
      READ: begin
        bus.mem_addr = {eff_src, index_q};
      end
      WRITE: begin
        bus.mem_addr  = OAM_BASE + {8'h00, index_q};
        bus.mem_wdata = buffer_q;
        bus.mem_write = !reg_wr;
      end
      default: begin
        bus.mem_write = bus.cpu_write && !hram_hit && !reg_hit;
      end
    endcase
    if (rst_in) bus.mem_write = 1'b0;

    if (hram_hit)      bus.cpu_rdata = bus.hram_rdata;
    else if (reg_hit)  bus.cpu_rdata = src_q;
    else if (dma_busy) bus.cpu_rdata = 8'hFF;
    else               bus.cpu_rdata = bus.mem_rdata;
  end

  assign bus.dma_active = dma_active_q;

endmodule

// File: doc/oam_dma_arbiter.md
OAM_DMA_ARBITER -- requirements
Module: oam_dma_arbiter

Interface
REQ-001 Parameter DMA_LEN, 160: bytes per OAM DMA transfer.
REQ-002 Parameter OAM_BASE, 16'hFE00: DMA destination base address.
REQ-003 Parameter DMA_REG_ADDR, 16'hFF46: DMA start/source register address.
REQ-004 clk_in  input  1: system clock; the only clock.
REQ-005 rst_in  input  1: reset, asynchronous, active-high.
REQ-006 mclk_in  input  1: M-cycle strobe, one clk_in wide; all state advances only on clk_in edges where mclk_in=1.
REQ-007 cpu_addr  input  16: CPU bus address.
REQ-008 cpu_wdata  input  8: CPU write data.
REQ-009 cpu_write  input  1: CPU write request.
REQ-010 cpu_rdata  output  8: read data returned to CPU.
REQ-011 mem_addr  output  16: address to mem_map.
REQ-012 mem_wdata  output  8: write data to mem_map.
REQ-013 mem_write  output  1: write strobe to mem_map.
REQ-014 mem_rdata  input  8: read data from mem_map.
REQ-015 hram_addr  output  7: HRAM offset (cpu_addr - 16'hFF80).
REQ-016 hram_wdata  output  8: HRAM write data (= cpu_wdata).
REQ-017 hram_write  output  1: HRAM write strobe.
REQ-018 hram_rdata  input  8: HRAM read data.
REQ-019 dma_active  output  1: high while DMA owns mem port.

Function
REQ-020 States IDLE, START, READ, WRITE; 8-bit src register; 8-bit index counter; 8-bit byte buffer.
REQ-021 cpu_addr in FF80-FFFE always routes to the HRAM port regardless of state: hram_write=cpu_write, cpu_rdata=hram_rdata; mem_write=0 for that access.
REQ-022 cpu_addr=DMA_REG_ADDR: read returns src in any state; write with mclk_in=1 loads src<=cpu_wdata, index<=0, state<=START from any state (restart); never forwarded to mem port.
REQ-023 IDLE/START: all other CPU accesses pass through combinationally: mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_write=cpu_write, cpu_rdata=mem_rdata.
REQ-024 START -> READ on next mclk_in, index=0.
REQ-025 READ: mem_addr={eff_src,index}, mem_write=0; on mclk_in buffer<=mem_rdata, -> WRITE.
REQ-026 WRITE: mem_addr=OAM_BASE+index, mem_wdata=buffer, mem_write=1; on mclk_in: index=DMA_LEN-1 -> IDLE, else index+1 -> READ.
REQ-027 eff_src = src-8'h20 when src>=8'hE0, else src (echo-RAM mirror).
REQ-028 dma_active=1 exactly in READ/WRITE; transfer = 1 START + 2*DMA_LEN M-cycles.
REQ-029 READ/WRITE, CPU access outside HRAM and DMA_REG_ADDR: write dropped, cpu_rdata=8'hFF.
REQ-030 Restart write during READ/WRITE aborts current byte (no partial write issued after that mclk_in), restarts from index 0 with new src.
REQ-031 index never exceeds DMA_LEN-1; no wrap beyond OAM_BASE+DMA_LEN-1.

Reset
REQ-032 rst_in=1 immediately: state=IDLE, src=8'h00, index=0, buffer=8'h00, dma_active=0, mem_write forced 0, hram_write forced 0.
REQ-033 Reset mid-transfer abandons DMA; no further DMA writes after rst_in deasserts.

Verification
REQ-034 Write 8'hC1 to FF46 at M-cycle k -> READs at C100..C19F, writes FE00..FE9F with matching data; dma_active high from mclk k+1 to k+321; IDLE after.
REQ-035 Write 8'hE3 to FF46 -> reads from C300..C39F (mirror rule).
REQ-036 During DMA: CPU read of C000 -> 8'hFF, CPU write to C000 -> no mem_write; HRAM FF90 read/write -> hram port, hram_addr=7'h10; read FF46 -> src.
REQ-037 Write 8'hC2 to FF46 at index 50 -> next READ at C200, transfer completes FE00..FE9F from C2xx.
REQ-038 Assert rst_in asynchronously during WRITE -> mem_write=0 and dma_active=0 same cycle; src reads 8'h00 after reset.
REQ-039 IDLE pass-through: CPU write 8'h5A to C123 -> mem_addr=C123, mem_wdata=8'h5A, mem_write=1.
